// File: rtl/program_loader.sv
// Byte-serial program loader: accepts bytes from external pins and writes them into
// CPU RAM through the MAR address/data strobes, holding the CPU while loading.
module program_loader #(
  parameter int RAM_BYTES = 16
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ack,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       n_load_addr,
  output logic       n_load_data,
  output logic       ram_we_n,
  output logic       cpu_hold,
  output logic       loading,
  output logic       done,
  output logic [8:0] byte_count
);

  localparam int AW = $clog2(RAM_BYTES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_DRIVE_ADDR,
    S_DRIVE_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [8:0]      count_q, count_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic [7:0]      addr_ext;

  assign addr_ext   = 8'(addr_q);
  assign byte_count = count_q;
  assign cpu_hold   = loading;

  // Control state: cleared by reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // Captured byte and its last flag are only meaningful after acceptance.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    last_q <= last_d;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    byte_d      = byte_q;
    last_d      = last_q;
    in_ack      = 1'b0;
    bus_out     = 8'h00;
    bus_oe      = 1'b0;
    n_load_addr = 1'b1;
    n_load_data = 1'b1;
    ram_we_n    = 1'b1;
    loading     = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_WAIT_BYTE;
          addr_d  = '0;
          count_d = '0;
        end
      end
      S_WAIT_BYTE: begin
        loading = 1'b1;
        in_ack  = 1'b1;
        if (in_valid) begin
          byte_d  = in_data;
          last_d  = in_last;
          state_d = S_DRIVE_ADDR;
        end
      end
      S_DRIVE_ADDR: begin
        loading     = 1'b1;
        bus_out     = addr_ext;
        bus_oe      = 1'b1;
        n_load_addr = 1'b0;
        state_d     = S_DRIVE_DATA;
      end
      S_DRIVE_DATA: begin
        loading     = 1'b1;
        bus_out     = byte_q;
        bus_oe      = 1'b1;
        n_load_data = 1'b0;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        // Address wraps naturally at RAM_BYTES; the top location also ends the session.
        loading  = 1'b1;
        ram_we_n = 1'b0;
        count_d  = count_q + 9'd1;
        addr_d   = addr_q + AW'(1);
        state_d  = (last_q || (addr_q == LAST_ADDR)) ? S_DONE : S_WAIT_BYTE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001: Parameter RAM_BYTES, default 16, number of RAM locations to load; power of two, 2..256.
REQ-002: clk  input  1  system clock; all state changes on rising edge.
REQ-003: clear  input  1  reset; synchronous, active-high.
REQ-004: start  input  1  request to begin a load session; sampled only in IDLE and DONE.
REQ-005: in_data  input  8  program byte from external pins.
REQ-006: in_valid  input  1  in_data holds a valid byte.
REQ-007: in_last  input  1  current byte is the final byte of the program; qualified by in_valid.
REQ-008: in_ack  output  1  loader accepts in_data this cycle.
REQ-009: bus_out  output  8  value driven onto the CPU bus.
REQ-010: bus_oe  output  1  bus_out drive enable; bus released when low.
REQ-011: n_load_addr  output  1  MAR address load strobe; active-low.
REQ-012: n_load_data  output  1  MAR data load strobe; active-low.
REQ-013: ram_we_n  output  1  RAM write strobe; active-low.
REQ-014: cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-015: loading  output  1  high in WAIT_BYTE, DRIVE_ADDR, DRIVE_DATA and WRITE.
REQ-016: done  output  1  high in DONE.
REQ-017: byte_count  output  9  number of bytes written in the current session.

Function
REQ-018: The FSM SHALL have the states IDLE, WAIT_BYTE, DRIVE_ADDR, DRIVE_DATA, WRITE and DONE.
REQ-019: IDLE or DONE with start=1 -> WAIT_BYTE at the next edge; the internal address and byte_count SHALL clear to 0.
REQ-020: In any other state, start SHALL be ignored.
REQ-021: in_ack SHALL be high only in WAIT_BYTE; a byte SHALL be accepted only on an edge where in_valid=1 and in_ack=1.
REQ-022: On acceptance, in_data and in_last SHALL be captured and the FSM SHALL move to DRIVE_ADDR.
REQ-023: If in_valid=0 in WAIT_BYTE, the FSM SHALL remain in WAIT_BYTE indefinitely.
REQ-024: DRIVE_ADDR (1 cycle) SHALL drive bus_out = address zero-extended to 8 bits, with bus_oe=1 and n_load_addr=0.
REQ-025: DRIVE_DATA (1 cycle) SHALL drive bus_out = captured byte, with bus_oe=1 and n_load_data=0.
REQ-026: WRITE (1 cycle) SHALL drive ram_we_n=0 and bus_oe=0; byte_count SHALL increment on exit from WRITE.
REQ-027: On exit from WRITE, the address SHALL increment modulo RAM_BYTES.
REQ-028: On exit from WRITE, if the captured in_last=1 or the address was RAM_BYTES-1, the next state SHALL be DONE; otherwise it SHALL be WAIT_BYTE.
REQ-029: Latency: a byte accepted at edge N SHALL have its address strobe in cycle N+1, its data strobe in N+2 and its RAM write in N+3; in_ack SHALL return in N+4 (max throughput 1 byte per 4 cycles).
REQ-030: At most one of n_load_addr, n_load_data and ram_we_n SHALL be low in any cycle.
REQ-031: bus_oe SHALL be low in every state other than DRIVE_ADDR and DRIVE_DATA.
REQ-032: bus_out SHALL be 0 whenever bus_oe=0.
REQ-033: cpu_hold SHALL equal loading.
REQ-034: In DONE, done=1 and byte_count SHALL hold its final value until the next start or clear.

Reset
REQ-035: clear=1 SHALL force IDLE, address 0 and byte_count 0 at the next edge, overriding all other inputs including start.
REQ-036: After reset: in_ack=0, bus_out=0x00, bus_oe=0, n_load_addr=1, n_load_data=1, ram_we_n=1, cpu_hold=0, loading=0, done=0.
REQ-037: clear during a load SHALL abort the load; locations already written SHALL stay written, and the next start SHALL restart at address 0.

Verification
REQ-038: Single byte: start, then 0x5A with in_last=1 -> cycle 1 bus=0x00 with n_load_addr=0; cycle 2 bus=0x5A with n_load_data=0; cycle 3 ram_we_n=0; then done=1, byte_count=1, cpu_hold=0.
REQ-039: Full load: 16 bytes 0x10..0x1F with in_valid held high and in_last=0 -> addresses 0..15 written, DONE after the 16th write, byte_count=16, no further in_ack.
REQ-040: Stall: in_valid low for 10 cycles between bytes 2 and 3 -> in_ack stays high, no strobes fire, byte 3 is written to address 2.
REQ-041: Strobe exclusivity: across all scenarios, at most one strobe is low per cycle and bus_oe=0 whenever ram_we_n=0.
REQ-042: Clear mid-load: clear asserted in DRIVE_DATA of byte 4 -> next cycle IDLE with all strobes high and cpu_hold=0; a following start and byte 0xAA writes to address 0.
REQ-043: Start ignored: start pulsed during WAIT_BYTE after 3 bytes -> byte_count is unaffected and the next byte goes to address 3.
